// File: rtl/harness_pkg.sv
// ----------------------------------------------------------------------------
// harness_pkg
// Shared definitions for the tiny-project harness: Wishbone register offsets,
// register bit positions and the project-switch state encoding.
// ----------------------------------------------------------------------------
package harness_pkg;

  // Register offsets (wbs_adr_i[3:0])
  localparam logic [3:0] OFF_SEL     = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_IRQ_CLR = 4'h8;
  localparam logic [3:0] OFF_ID      = 4'hC;

  // STATUS bit positions
  localparam int STAT_BUSY       = 0;
  localparam int STAT_IRQ        = 1;
  localparam int STAT_ERR        = 2;
  localparam int STAT_ACTIVE_LSB = 8;

  // IRQ_CLR bit positions
  localparam int CLR_IRQ = 0;
  localparam int CLR_ERR = 2;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_ISOLATE = 2'd1,
    ST_HOLD    = 2'd2
  } harness_state_e;

endpackage

// File: rtl/harness_io_mux.sv
// ----------------------------------------------------------------------------
// harness_io_mux
// Registered NUM_PROJECTS:1 pad multiplexer with an isolate override.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   isolate           1 = pads isolated (out 0, oeb 1) on the next edge
//   sel               index of the project routed to the pads
//   proj_io_out/oeb   flattened project outputs, project k at [k*IO_PADS +: IO_PADS]
//   io_out/io_oeb     registered pad drive / output-enable-bar
// ----------------------------------------------------------------------------
module harness_io_mux #(
  parameter int NUM_PROJECTS = 4,
  parameter int IO_PADS      = 38,
  parameter int AW           = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            isolate,
  input  logic [AW-1:0]                   sel,
  input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_out,
  input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_oeb,
  output logic [IO_PADS-1:0]              io_out,
  output logic [IO_PADS-1:0]              io_oeb
);

  logic [IO_PADS-1:0] out_mux;
  logic [IO_PADS-1:0] oeb_mux;

  always_comb begin
    out_mux = '0;
    oeb_mux = '1;
    for (int k = 0; k < NUM_PROJECTS; k++) begin
      if (sel == AW'(k)) begin
        out_mux = proj_io_out[k*IO_PADS +: IO_PADS];
        oeb_mux = proj_io_oeb[k*IO_PADS +: IO_PADS];
      end
    end
  end

  // Pad register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_out <= '0;
      io_oeb <= '1;
    end else if (isolate) begin
      io_out <= '0;
      io_oeb <= '1;
    end else begin
      io_out <= out_mux;
      io_oeb <= oeb_mux;
    end
  end

endmodule

// File: rtl/tiny_project_harness.sv
// ----------------------------------------------------------------------------
// tiny_project_harness
// Hosts NUM_PROJECTS tiny user projects and routes one of them to the pads.
// A Wishbone register block selects the active project; a switch FSM
// isolates the pads, holds the new project in reset for RESET_CYCLES, then
// releases it and raises user_irq[0].
// Ports:
//   wb_clk_i, wb_rst_i           clock, asynchronous active-high reset
//   wbs_*                        Wishbone slave (SEL/STATUS/IRQ_CLR/ID)
//   io_in / io_out / io_oeb      Caravel pads
//   proj_io_in                   io_in broadcast to every project
//   proj_io_out / proj_io_oeb    project outputs, project k at [k*IO_PADS +: IO_PADS]
//   proj_rst_o                   per-project active-high reset
//   user_irq                     [0] switch-done pending, [2:1] zero
// ----------------------------------------------------------------------------
module tiny_project_harness
  import harness_pkg::*;
#(
  parameter int          NUM_PROJECTS = 4,
  parameter int          IO_PADS      = 38,
  parameter int          RESET_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic                            wbs_stb_i,
  input  logic                            wbs_cyc_i,
  input  logic                            wbs_we_i,
  input  logic [3:0]                      wbs_sel_i,
  input  logic [31:0]                     wbs_adr_i,
  input  logic [31:0]                     wbs_dat_i,
  output logic                            wbs_ack_o,
  output logic [31:0]                     wbs_dat_o,
  input  logic [IO_PADS-1:0]              io_in,
  output logic [IO_PADS-1:0]              io_out,
  output logic [IO_PADS-1:0]              io_oeb,
  output logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_in,
  input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_out,
  input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_oeb,
  output logic [NUM_PROJECTS-1:0]         proj_rst_o,
  output logic [2:0]                      user_irq
);

  localparam int AW = (NUM_PROJECTS > 1) ? $clog2(NUM_PROJECTS) : 1;
  localparam int CW = $clog2(RESET_CYCLES + 1);

  harness_state_e state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  active_q;
  logic           irq_pending_q;
  logic           err_q;
  logic           first_done_q;

  logic           req;
  logic [3:0]     offset;
  logic           sel_wr;
  logic           sel_ok;
  logic           clr_wr;
  logic           busy;
  logic           run_entry;
  logic [31:0]    rd_data;
  logic           unused_ok;

  assign unused_ok = ^{wbs_sel_i, wbs_dat_i[31:8]};

  assign offset  = wbs_adr_i[3:0];
  assign req     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~wbs_ack_o;
  assign sel_wr  = req & wbs_we_i & (offset == OFF_SEL);
  assign clr_wr  = req & wbs_we_i & (offset == OFF_IRQ_CLR);
  assign busy    = (state_q != ST_RUN);
  // A switch is only taken from RUN with an in-range index; anything else is an error.
  assign sel_ok  = ~busy & ({1'b0, wbs_dat_i[7:0]} < 9'(NUM_PROJECTS));
  assign run_entry = (state_q == ST_HOLD) & (state_d == ST_RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (sel_wr && sel_ok) state_d = ST_ISOLATE;
      end
      ST_ISOLATE: begin
        state_d = ST_HOLD;
        cnt_d   = CW'(RESET_CYCLES);
      end
      ST_HOLD: begin
        if (cnt_q == CW'(1)) state_d = ST_RUN;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = CW'(RESET_CYCLES);
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_HOLD;
      cnt_q   <= CW'(RESET_CYCLES);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (offset)
      OFF_SEL: rd_data[AW-1:0] = active_q;
      OFF_STATUS: begin
        rd_data[STAT_BUSY]                = busy;
        rd_data[STAT_IRQ]                 = irq_pending_q;
        rd_data[STAT_ERR]                 = err_q;
        rd_data[STAT_ACTIVE_LSB +: AW]    = active_q;
      end
      OFF_ID:  rd_data = {16'(RESET_CYCLES), 16'(NUM_PROJECTS)};
      default: rd_data = '0;
    endcase
  end

  // Register block: bus response and control/status state
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= '0;
      active_q      <= '0;
      irq_pending_q <= 1'b0;
      err_q         <= 1'b0;
      first_done_q  <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rd_data : '0;
      if (sel_wr && sel_ok) active_q <= wbs_dat_i[AW-1:0];
      if (sel_wr && !sel_ok)                  err_q <= 1'b1;
      else if (clr_wr && wbs_dat_i[CLR_ERR])  err_q <= 1'b0;
      // The release that follows reset is not a requested switch, so it stays silent.
      if (run_entry && first_done_q)          irq_pending_q <= 1'b1;
      else if (clr_wr && wbs_dat_i[CLR_IRQ])  irq_pending_q <= 1'b0;
      if (run_entry) first_done_q <= 1'b1;
    end
  end

  always_comb begin
    proj_rst_o = '1;
    for (int k = 0; k < NUM_PROJECTS; k++) begin
      if (!busy && active_q == AW'(k)) proj_rst_o[k] = 1'b0;
    end
  end

  assign proj_io_in = {NUM_PROJECTS{io_in}};
  assign user_irq   = {2'b00, irq_pending_q};

  // The pad register looks at the next state so routing lands on the RUN-entry cycle.
  harness_io_mux #(
    .NUM_PROJECTS(NUM_PROJECTS),
    .IO_PADS     (IO_PADS),
    .AW          (AW)
  ) u_io_mux (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .isolate    (state_d != ST_RUN),
    .sel        (active_q),
    .proj_io_out(proj_io_out),
    .proj_io_oeb(proj_io_oeb),
    .io_out     (io_out),
    .io_oeb     (io_oeb)
  );

endmodule

// File: tb/tb_tiny_project_harness.sv
// ----------------------------------------------------------------------------
// tb_tiny_project_harness
// Self-checking bench for tiny_project_harness: randomized pad traffic and
// Wishbone accesses compared every cycle against a behavioural model that
// tracks "cycles left until the active project runs".
// ----------------------------------------------------------------------------
module tb_tiny_project_harness;

  localparam int          NP   = 4;
  localparam int          PADS = 38;
  localparam int          RC   = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          VW   = 160;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]           sel = 4'hF;
  logic [31:0]          adr = '0, wdat = '0;
  logic                 ack;
  logic [31:0]          rdat;
  logic [PADS-1:0]      io_in = '0;
  logic [PADS-1:0]      io_out, io_oeb;
  logic [NP*PADS-1:0]   proj_io_in;
  logic [NP*PADS-1:0]   proj_io_out = '0, proj_io_oeb = '0;
  logic [NP-1:0]        proj_rst;
  logic [2:0]           user_irq;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int              m_rem;
  int              m_active;
  bit              m_irq, m_err, m_first, m_ack;
  logic [31:0]     m_dat;
  logic [PADS-1:0] m_out, m_oeb;

  always #5 clk = ~clk;

  tiny_project_harness #(
    .NUM_PROJECTS(NP), .IO_PADS(PADS), .RESET_CYCLES(RC), .BASE_ADDR(BASE)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .proj_io_in(proj_io_in), .proj_io_out(proj_io_out), .proj_io_oeb(proj_io_oeb),
    .proj_rst_o(proj_rst), .user_irq(user_irq)
  );

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] off);
    logic [31:0] r;
    r = '0;
    case (off)
      4'h0: r = 32'(m_active);
      4'h4: r = {16'h0, 8'(m_active), 5'b0, m_err, m_irq, (m_rem != 0)};
      4'hC: r = {16'(RC), 16'(NP)};
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_rem = RC; m_active = 0; m_irq = 0; m_err = 0; m_first = 1; m_ack = 0;
    m_dat = '0; m_out = '0; m_oeb = '1;
  endtask

  // Advance the model across one rising edge, using the inputs held at that edge.
  task automatic model_step();
    bit req, sel_wr, clr_wr, sel_ok;
    int rem_n;
    logic [31:0] dat_n;
    if (rst) begin
      model_reset();
      return;
    end
    req    = stb && cyc && (adr[31:4] == BASE[31:4]) && !m_ack;
    sel_wr = req && we && (adr[3:0] == 4'h0);
    clr_wr = req && we && (adr[3:0] == 4'h8);
    sel_ok = sel_wr && (m_rem == 0) && (int'(wdat[7:0]) < NP);
    dat_n  = (req && !we) ? model_read(adr[3:0]) : 32'h0;
    if (m_rem == 1 && !m_first) m_irq = 1;
    else if (clr_wr && wdat[0]) m_irq = 0;
    if (m_rem == 1) m_first = 0;
    if (sel_wr && !sel_ok)      m_err = 1;
    else if (clr_wr && wdat[2]) m_err = 0;
    if (m_rem > 0)   rem_n = m_rem - 1;
    else if (sel_ok) rem_n = RC + 1;
    else             rem_n = 0;
    if (sel_ok) m_active = int'(wdat[7:0]);
    m_rem = rem_n;
    if (m_rem > 0) begin
      m_out = '0;
      m_oeb = '1;
    end else begin
      m_out = proj_io_out[m_active*PADS +: PADS];
      m_oeb = proj_io_oeb[m_active*PADS +: PADS];
    end
    m_ack = req;
    m_dat = dat_n;
  endtask

  task automatic rand_pads();
    logic [63:0] r;
    r = {$urandom, $urandom};
    io_in = r[PADS-1:0];
    for (int k = 0; k < NP; k++) begin
      r = {$urandom, $urandom};
      proj_io_out[k*PADS +: PADS] = r[PADS-1:0];
      r = {$urandom, $urandom};
      proj_io_oeb[k*PADS +: PADS] = r[PADS-1:0];
    end
  endtask

  // One clock: step the model, compare every output, then change pad inputs.
  task automatic tick();
    logic [NP-1:0] exp_rst;
    @(negedge clk);
    model_step();
    exp_rst = '1;
    if (m_rem == 0) exp_rst[m_active] = 1'b0;
    check("ack",        VW'(ack),        VW'(m_ack));
    check("dat_o",      VW'(rdat),       VW'(m_dat));
    check("io_out",     VW'(io_out),     VW'(m_out));
    check("io_oeb",     VW'(io_oeb),     VW'(m_oeb));
    check("proj_rst",   VW'(proj_rst),   VW'(exp_rst));
    check("user_irq",   VW'(user_irq),   VW'({2'b00, m_irq}));
    check("proj_io_in", VW'(proj_io_in), VW'({NP{io_in}}));
    rand_pads();
  endtask

  // Drive one Wishbone request held for 'hold' cycles; returns data seen after the first edge.
  task automatic wb_xact(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input int hold, output logic [31:0] rd);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
    tick();
    rd = rdat;
    for (int i = 1; i < hold; i++) tick();
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic wb_write(input logic [3:0] off, input logic [31:0] d);
    logic [31:0] unused_rd;
    wb_xact(BASE | 32'(off), 1'b1, d, 1, unused_rd);
  endtask

  task automatic wb_read(input logic [3:0] off, output logic [31:0] d);
    wb_xact(BASE | 32'(off), 1'b0, 32'h0, 1, d);
  endtask

  initial begin
    logic [31:0] d;
    model_reset();
    rand_pads();
    tick();
    tick();
    rst = 1'b0;

    // Reset release: all projects held for RC cycles, then project 0 runs silently.
    repeat (RC - 1) tick();
    check("rel_hold_rst", VW'(proj_rst), VW'(4'b1111));
    check("rel_hold_oeb", VW'(io_oeb),   VW'({PADS{1'b1}}));
    tick();
    check("rel_run_rst",  VW'(proj_rst), VW'(4'b1110));
    check("rel_run_irq",  VW'(user_irq[0]), VW'(1'b0));

    wb_read(4'hC, d);
    check("id_reg", VW'(d), VW'(32'h0010_0004));

    // Switch to project 2.
    wb_write(4'h0, 32'd2);
    check("sw2_iso_oeb", VW'(io_oeb),   VW'({PADS{1'b1}}));
    check("sw2_iso_rst", VW'(proj_rst), VW'(4'b1111));
    repeat (RC - 1) tick();
    check("sw2_hold_rst", VW'(proj_rst), VW'(4'b1111));
    tick();
    check("sw2_run_rst", VW'(proj_rst),    VW'(4'b1011));
    check("sw2_irq",     VW'(user_irq[0]), VW'(1'b1));
    wb_read(4'h4, d);
    check("sw2_status",  VW'(d), VW'(32'h0000_0202));

    // Out-of-range index: acked, ignored, err set; then cleared by W1C.
    wb_write(4'h8, 32'h1);
    wb_write(4'h0, 32'd7);
    wb_read(4'h4, d);
    check("bad_idx_status", VW'(d), VW'(32'h0000_0204));
    wb_write(4'h8, 32'h4);
    wb_read(4'h4, d);
    check("err_cleared", VW'(d), VW'(32'h0000_0200));

    // Write during HOLD is rejected; original switch still completes on time.
    wb_write(4'h0, 32'd1);
    repeat (3) tick();
    wb_write(4'h0, 32'd3);
    repeat (RC - 6) tick();
    check("busy_hold_rst", VW'(proj_rst), VW'(4'b1111));
    tick();
    check("busy_run_rst", VW'(proj_rst), VW'(4'b1101));
    wb_read(4'h4, d);
    check("busy_status", VW'(d), VW'(32'h0000_0106));
    wb_write(4'h8, 32'h5);

    // IRQ_CLR landing on the HOLD->RUN edge: set wins.
    wb_write(4'h0, 32'd0);
    repeat (RC - 1) tick();
    wb_write(4'h8, 32'h1);
    check("set_wins_irq", VW'(user_irq[0]), VW'(1'b1));
    wb_write(4'h8, 32'h1);

    // Reset pulse in the 5th HOLD cycle abandons the switch.
    wb_write(4'h0, 32'd3);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wb_read(4'h4, d);
    check("rst_mid_status", VW'(d), VW'(32'h0000_0001));
    repeat (RC - 2) tick();
    check("rst_mid_run_rst", VW'(proj_rst),    VW'(4'b1110));
    check("rst_mid_irq",     VW'(user_irq[0]), VW'(1'b0));

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 5);
      a  = BASE | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) a = a ^ 32'h0000_0100;
      case (op)
        0: tick();
        1: wb_xact(a, 1'b0, 32'h0, 1, d);
        2: wb_write(4'h0, 32'($urandom_range(0, 7)));
        3: wb_write(4'h8, 32'($urandom_range(0, 7)));
        4: wb_xact(a, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 5)),
                   $urandom_range(2, 5), d);
        default: begin
          wb_write(4'h0, 32'($urandom_range(0, 3)));
          repeat (RC + 3) tick();
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
